// File: rtl/toy_pack.sv
// Shared types and defaults for the toy board-level support blocks.
package toy_pack;

    typedef enum logic [1:0] {LED_RUN, LED_PASS, LED_FAIL} led_state_e;

    localparam int unsigned TOHOST_ADDR_DEF = 'h0;

endpackage

// File: rtl/toy_tick_gen.sv
// Free-running prescaler: counts 0..CNT_MAX, wraps, and flags the terminal count.
module toy_tick_gen #(
    parameter int unsigned CNT_MAX = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CW'(CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/toy_led_status_ctrl.sv
// Board-status LEDs: rotating run pattern, solid on pass, blink on fail, driven by tohost snooping.
// Build option TOY_LED_FAIL_CODE_EN: FAIL blinks the low exit-code bits instead of all ones.
//
// state    | meaning
// LED_RUN  | program running, one lit LED rotates left on each tick
// LED_PASS | exit code 0 captured, all LEDs lit (terminal)
// LED_FAIL | non-zero exit code captured, pattern blinks on each tick (terminal)
module toy_led_status_ctrl
    import toy_pack::*;
#(
    parameter int unsigned LED_NUM      = 4,
    parameter int unsigned TICK_CNT_MAX = 10000000,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(TOHOST_ADDR_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ext_mem_en,
    input  logic                    ext_mem_wr_en,
    input  logic [ADDR_WIDTH-1:0]   ext_mem_addr,
    input  logic [DATA_WIDTH-1:0]   ext_mem_wr_data,
    input  logic [DATA_WIDTH/8-1:0] ext_mem_wr_be,
    output logic [LED_NUM-1:0]      led_o,
    output logic                    host_done_o,
    output logic                    host_pass_o,
    output logic [DATA_WIDTH-2:0]   host_code_o
);

    led_state_e            state_q, state_nxt;
    logic [LED_NUM-1:0]    led_q, led_nxt;
    logic                  phase_q, phase_nxt;
    logic                  done_q, done_nxt;
    logic                  pass_q, pass_nxt;
    logic [DATA_WIDTH-2:0] code_q, code_nxt;

    logic                  tick;
    logic                  exit_evt;
    logic [DATA_WIDTH-2:0] code_cap;
    logic [LED_NUM-1:0]    fail_cap;
    logic [LED_NUM-1:0]    fail_hold;
    logic                  unused_be;

    toy_tick_gen #(
        .CNT_MAX (TICK_CNT_MAX)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign unused_be = &ext_mem_wr_be;
    assign code_cap  = ext_mem_wr_data[DATA_WIDTH-1:1];
    assign exit_evt  = ext_mem_en & ext_mem_wr_en & (ext_mem_addr == TOHOST_ADDR)
                     & ext_mem_wr_be[0] & ext_mem_wr_data[0];

`ifdef TOY_LED_FAIL_CODE_EN
    // Zero-pad so narrow codes still fill a wide LED bank.
    logic [LED_NUM+DATA_WIDTH-2:0] code_cap_ext;
    logic [LED_NUM+DATA_WIDTH-2:0] code_hold_ext;
    assign code_cap_ext  = {{LED_NUM{1'b0}}, code_cap};
    assign code_hold_ext = {{LED_NUM{1'b0}}, code_q};
    assign fail_cap      = code_cap_ext[LED_NUM-1:0];
    assign fail_hold     = code_hold_ext[LED_NUM-1:0];
`else
    assign fail_cap  = '1;
    assign fail_hold = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LED_RUN;
            led_q   <= LED_NUM'(1);
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_nxt;
            led_q   <= led_nxt;
            phase_q <= phase_nxt;
            done_q  <= done_nxt;
            pass_q  <= pass_nxt;
            code_q  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        led_nxt   = led_q;
        phase_nxt = phase_q;
        done_nxt  = done_q;
        pass_nxt  = pass_q;
        code_nxt  = code_q;
        case (state_q)
            LED_RUN: begin
                // An exit event pre-empts a coincident rotation.
                if (exit_evt) begin
                    code_nxt  = code_cap;
                    done_nxt  = 1'b1;
                    pass_nxt  = (code_cap == '0);
                    phase_nxt = 1'b0;
                    if (code_cap == '0) begin
                        state_nxt = LED_PASS;
                        led_nxt   = '1;
                    end else begin
                        state_nxt = LED_FAIL;
                        led_nxt   = fail_cap;
                    end
                end else if (tick) begin
                    led_nxt = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
                end
            end
            LED_PASS: begin
                led_nxt = '1;
            end
            LED_FAIL: begin
                if (tick) begin
                    phase_nxt = ~phase_q;
                    led_nxt   = phase_q ? fail_hold : '0;
                end
            end
            default: begin
                state_nxt = LED_RUN;
                led_nxt   = LED_NUM'(1);
            end
        endcase
    end

    assign led_o       = led_q;
    assign host_done_o = done_q;
    assign host_pass_o = pass_q;
    assign host_code_o = code_q;

endmodule

// File: tb/tb_toy_led_status_ctrl.sv
// Directed bench for toy_led_status_ctrl (LED_NUM=4, TICK_CNT_MAX=3, TOHOST_ADDR=0).
module tb_toy_led_status_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_mem_en;
    logic        ext_mem_wr_en;
    logic [31:0] ext_mem_addr;
    logic [31:0] ext_mem_wr_data;
    logic [3:0]  ext_mem_wr_be;
    logic [3:0]  led_o;
    logic        host_done_o;
    logic        host_pass_o;
    logic [30:0] host_code_o;

    int checks = 0;
    int errors = 0;

`ifdef TOY_LED_FAIL_CODE_EN
    localparam logic [3:0] FAIL_ON5 = 4'b0101;
    localparam logic [3:0] FAIL_ON1 = 4'b0001;
`else
    localparam logic [3:0] FAIL_ON5 = 4'b1111;
    localparam logic [3:0] FAIL_ON1 = 4'b1111;
`endif

    toy_led_status_ctrl #(
        .LED_NUM      (4),
        .TICK_CNT_MAX (3),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .TOHOST_ADDR  (32'h0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ext_mem_en      (ext_mem_en),
        .ext_mem_wr_en   (ext_mem_wr_en),
        .ext_mem_addr    (ext_mem_addr),
        .ext_mem_wr_data (ext_mem_wr_data),
        .ext_mem_wr_be   (ext_mem_wr_be),
        .led_o           (led_o),
        .host_done_o     (host_done_o),
        .host_pass_o     (host_pass_o),
        .host_code_o     (host_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one write across exactly one rising edge; called at a falling edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        ext_mem_en      = 1'b1;
        ext_mem_wr_en   = 1'b1;
        ext_mem_addr    = addr;
        ext_mem_wr_data = data;
        ext_mem_wr_be   = be;
        @(negedge clk);
        ext_mem_en      = 1'b0;
        ext_mem_wr_en   = 1'b0;
        ext_mem_addr    = '0;
        ext_mem_wr_data = '0;
        ext_mem_wr_be   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        ext_mem_en      = 1'b0;
        ext_mem_wr_en   = 1'b0;
        ext_mem_addr    = '0;
        ext_mem_wr_data = '0;
        ext_mem_wr_be   = '0;

        // Reset values
        @(negedge clk);
        chk("rst_led",  {28'd0, led_o}, 32'h1);
        chk("rst_done", {31'd0, host_done_o}, 32'h0);
        chk("rst_pass", {31'd0, host_pass_o}, 32'h0);
        chk("rst_code", {1'b0, host_code_o}, 32'h0);
        rst_n = 1'b1;

        // Rotation: ticks at edges 4, 8, 12, 16 after release
        cycles(3);  chk("run_pre_tick", {28'd0, led_o}, 32'h1);
        cycles(1);  chk("run_rot1", {28'd0, led_o}, 32'h2);
        cycles(4);  chk("run_rot2", {28'd0, led_o}, 32'h4);
        cycles(4);  chk("run_rot3", {28'd0, led_o}, 32'h8);
        cycles(4);  chk("run_wrap", {28'd0, led_o}, 32'h1);

        // Pass
        wr(32'h0, 32'h1, 4'hF);
        chk("pass_done", {31'd0, host_done_o}, 32'h1);
        chk("pass_pass", {31'd0, host_pass_o}, 32'h1);
        chk("pass_code", {1'b0, host_code_o}, 32'h0);
        chk("pass_led",  {28'd0, led_o}, 32'hF);
        cycles(20);
        chk("pass_led_hold", {28'd0, led_o}, 32'hF);
        wr(32'h0, 32'hB, 4'hF);
        chk("pass_ignore_code", {1'b0, host_code_o}, 32'h0);
        chk("pass_ignore_pass", {31'd0, host_pass_o}, 32'h1);

        // Fail with code 5, write lands on edge 1 after release
        do_reset();
        wr(32'h0, 32'hB, 4'hF);
        chk("fail_code", {1'b0, host_code_o}, 32'h5);
        chk("fail_pass", {31'd0, host_pass_o}, 32'h0);
        chk("fail_done", {31'd0, host_done_o}, 32'h1);
        chk("fail_led_on0", {28'd0, led_o}, {28'd0, FAIL_ON5});
        cycles(2);  chk("fail_led_on1", {28'd0, led_o}, {28'd0, FAIL_ON5});
        cycles(1);  chk("fail_led_off", {28'd0, led_o}, 32'h0);
        cycles(4);  chk("fail_led_on2", {28'd0, led_o}, {28'd0, FAIL_ON5});
        cycles(2);
        // Asynchronous reset mid-blink
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led",  {28'd0, led_o}, 32'h1);
        chk("arst_done", {31'd0, host_done_o}, 32'h0);
        chk("arst_code", {1'b0, host_code_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);  chk("arst_run_resume", {28'd0, led_o}, 32'h2);

        // Non-qualifying writes, then two exits where only the first counts
        do_reset();
        wr(32'h0, 32'h2, 4'hF);
        wr(32'h4, 32'h1, 4'hF);
        wr(32'h0, 32'h1, 4'hE);
        chk("nowr_done", {31'd0, host_done_o}, 32'h0);
        cycles(1);
        chk("nowr_run_rot", {28'd0, led_o}, 32'h2);
        wr(32'h0, 32'h3, 4'hF);
        chk("first_code", {1'b0, host_code_o}, 32'h1);
        chk("first_pass", {31'd0, host_pass_o}, 32'h0);
        chk("first_led",  {28'd0, led_o}, {28'd0, FAIL_ON1});
        wr(32'h0, 32'h1, 4'hF);
        chk("second_code", {1'b0, host_code_o}, 32'h1);
        chk("second_pass", {31'd0, host_pass_o}, 32'h0);
        cycles(2);  chk("second_led_off", {28'd0, led_o}, 32'h0);

        // Exit coinciding with a tick: no rotation, pass pattern next cycle
        do_reset();
        cycles(3);
        chk("coin_pre", {28'd0, led_o}, 32'h1);
        wr(32'h0, 32'h1, 4'h1);
        chk("coin_led",  {28'd0, led_o}, 32'hF);
        chk("coin_done", {31'd0, host_done_o}, 32'h1);
        chk("coin_pass", {31'd0, host_pass_o}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
